// File: rtl/strike_generator.sv
// rtl/strike_generator.sv - strike / ghost-eaten pulse generator with invulnerability window
//
// Purpose:
//   Counts pacman/ghost pixel overlap during each video frame and classifies it
//   when the next frame starts. Overlap on a normal ghost issues a one-cycle
//   strike pulse and opens an invulnerability window. Overlap on a frightened
//   ghost issues a one-cycle ghostEaten pulse. A gameOver pulse moves the block
//   into a terminal DEAD state that only reset leaves.
//
// Optional feature:
//   STRIKE_BLINK_EN - when defined, pacmanVisible blinks during the
//   invulnerability window; when undefined, pacmanVisible is tied to 1.
//
// Ports:
//   clk_i                   system clock
//   reset_i                 synchronous active-high reset
//   startOfFrame_i          one-cycle pulse at the first pixel of a frame
//   pacmanDrawingRequest_i  pacman pixel active
//   ghostDrawingRequest_i   any ghost pixel active
//   ghostFrightened_i       power-pellet mode (level)
//   gameOver_i              one-cycle pulse from the lives bitmap
//   strike_o                one-cycle pulse: pacman lost a life
//   ghostEaten_o            one-cycle pulse: pacman ate a ghost
//   invulnerable_o          high while the invulnerability window runs
//   pacmanVisible_o         pacman draw enable
//   dead_o                  high in the terminal state

module strike_generator #(
    parameter int MIN_OVERLAP   = 4,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8,
    parameter int LIVES         = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic startOfFrame_i,
    input  logic pacmanDrawingRequest_i,
    input  logic ghostDrawingRequest_i,
    input  logic ghostFrightened_i,
    input  logic gameOver_i,
    output logic strike_o,
    output logic ghostEaten_o,
    output logic invulnerable_o,
    output logic pacmanVisible_o,
    output logic dead_o
);

    localparam int FW = $clog2(INVULN_FRAMES + 1);
    localparam int SW = $clog2(LIVES + 1);

    localparam logic [7:0]    MIN_OV      = 8'(MIN_OVERLAP);
    localparam logic [FW-1:0] INVULN_LOAD = FW'(INVULN_FRAMES);
    localparam logic [SW-1:0] LIVES_MAX   = SW'(LIVES);

    if (MIN_OVERLAP < 1 || INVULN_FRAMES < 1 || BLINK_FRAMES < 1 || LIVES < 1) begin : g_bad_param
        $error("strike_generator: all parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t        state_q;
    logic [7:0]    hit_cnt_q, hit_cnt_d;
    logic [7:0]    eat_cnt_q, eat_cnt_d;
    logic [FW-1:0] frame_cnt_q;
    logic [SW-1:0] strikes_q;
    logic          strike_q, eaten_q, invuln_q, dead_q;

    logic hit_px, eat_px, hit_met, eat_met;
    logic frame_eval, enter_invuln, leave_invuln;

    assign hit_px  = pacmanDrawingRequest_i & ghostDrawingRequest_i & ~ghostFrightened_i;
    assign eat_px  = pacmanDrawingRequest_i & ghostDrawingRequest_i &  ghostFrightened_i;
    assign hit_met = (hit_cnt_q >= MIN_OV);
    assign eat_met = (eat_cnt_q >= MIN_OV);

    // gameOver pre-empts frame evaluation, so a coincident frame start yields no pulse.
    assign frame_eval   = startOfFrame_i & ~gameOver_i;
    assign enter_invuln = frame_eval & (state_q == ARMED) & hit_met & (strikes_q < LIVES_MAX);
    assign leave_invuln = frame_eval & (state_q == INVULN) & (frame_cnt_q == FW'(1));

    // At a frame start the old counts are sampled and the current pixel seeds the new frame.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        eat_cnt_d = eat_cnt_q;
        if (startOfFrame_i) begin
            hit_cnt_d = {7'd0, hit_px};
            eat_cnt_d = {7'd0, eat_px};
        end else begin
            if (hit_px && hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
            if (eat_px && eat_cnt_q != 8'hFF) eat_cnt_d = eat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ARMED;
            hit_cnt_q   <= '0;
            eat_cnt_q   <= '0;
            frame_cnt_q <= '0;
            strikes_q   <= '0;
            strike_q    <= 1'b0;
            eaten_q     <= 1'b0;
            invuln_q    <= 1'b0;
            dead_q      <= 1'b0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            eat_cnt_q <= eat_cnt_d;
            strike_q  <= 1'b0;
            eaten_q   <= 1'b0;
            if (gameOver_i) begin
                state_q  <= DEAD;
                invuln_q <= 1'b0;
                dead_q   <= 1'b1;
            end else if (startOfFrame_i) begin
                case (state_q)
                    ARMED: begin
                        eaten_q <= eat_met;
                        if (enter_invuln) begin
                            strike_q    <= 1'b1;
                            strikes_q   <= strikes_q + SW'(1);
                            state_q     <= INVULN;
                            frame_cnt_q <= INVULN_LOAD;
                            invuln_q    <= 1'b1;
                        end
                    end
                    INVULN: begin
                        // hitCnt is deliberately ignored: this sample belongs to an invulnerable frame.
                        eaten_q     <= eat_met;
                        frame_cnt_q <= frame_cnt_q - FW'(1);
                        if (leave_invuln) begin
                            state_q  <= ARMED;
                            invuln_q <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef STRIKE_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic          vis_q;
    logic [BW-1:0] blink_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vis_q       <= 1'b1;
            blink_cnt_q <= '0;
        end else if (gameOver_i) begin
            vis_q <= 1'b0;
        end else if (enter_invuln) begin
            vis_q       <= 1'b0;
            blink_cnt_q <= '0;
        end else if (leave_invuln) begin
            vis_q <= 1'b1;
        end else if (startOfFrame_i && state_q == INVULN) begin
            if (blink_cnt_q == BLINK_LAST) begin
                vis_q       <= ~vis_q;
                blink_cnt_q <= '0;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    assign pacmanVisible_o = vis_q;
`else
    assign pacmanVisible_o = 1'b1;
`endif

    assign strike_o       = strike_q;
    assign ghostEaten_o   = eaten_q;
    assign invulnerable_o = invuln_q;
    assign dead_o         = dead_q;

endmodule

// File: tb/tb_strike_generator.sv
// tb/tb_strike_generator.sv - scoreboard bench for strike_generator

module tb_strike_generator;

    localparam int MIN_OVERLAP   = 4;
    localparam int INVULN_FRAMES = 120;
    localparam int BLINK_FRAMES  = 8;
    localparam int LIVES         = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sof = 1'b0, pac = 1'b0, gh = 1'b0, fr = 1'b0, go = 1'b0;
    logic strike, eaten, invuln, vis, dead;

    int n_tests = 0;
    int n_fail  = 0;

    strike_generator #(
        .MIN_OVERLAP  (MIN_OVERLAP),
        .INVULN_FRAMES(INVULN_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .LIVES        (LIVES)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .startOfFrame_i        (sof),
        .pacmanDrawingRequest_i(pac),
        .ghostDrawingRequest_i (gh),
        .ghostFrightened_i     (fr),
        .gameOver_i            (go),
        .strike_o              (strike),
        .ghostEaten_o          (eaten),
        .invulnerable_o        (invuln),
        .pacmanVisible_o       (vis),
        .dead_o                (dead)
    );

    always #5 clk = ~clk;

    // Expected {strike, ghostEaten, invulnerable, dead, pacmanVisible} for the cycle after an event.
    logic [4:0] exp_q[$];

    // Reference model: game mode, invulnerable frame index, lives used, per-frame overlap tallies.
    localparam int M_ARMED = 0, M_INVULN = 1, M_DEAD = 2;
    int m_mode, m_inv_frame, m_strikes, m_hits, m_eats;

    function automatic logic model_vis();
`ifdef STRIKE_BLINK_EN
        if (m_mode == M_DEAD)   return 1'b0;
        if (m_mode == M_INVULN) return (((m_inv_frame - 1) / BLINK_FRAMES) % 2) != 0;
        return 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_mode = M_ARMED; m_inv_frame = 0; m_strikes = 0; m_hits = 0; m_eats = 0;
    endtask

    task automatic model_cycle(input bit s, input bit g, input bit p, input bit q, input bit f);
        bit es, ee;
        if (g) begin
            m_mode = M_DEAD;
            exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, model_vis()});
        end else if (s) begin
            es = 0;
            ee = (m_mode != M_DEAD) && (m_eats >= MIN_OVERLAP);
            if (m_mode == M_ARMED) begin
                if (m_hits >= MIN_OVERLAP && m_strikes < LIVES) begin
                    es = 1; m_strikes++; m_mode = M_INVULN; m_inv_frame = 1;
                end
            end else if (m_mode == M_INVULN) begin
                if (m_inv_frame == INVULN_FRAMES) m_mode = M_ARMED;
                else m_inv_frame++;
            end
            exp_q.push_back({es, ee, m_mode == M_INVULN, m_mode == M_DEAD, model_vis()});
        end
        if (s) begin m_hits = 0; m_eats = 0; end
        if (p && q) begin
            if (f) m_eats++; else m_hits++;
        end
    endtask

    task automatic drive(input bit s, input bit g, input bit p, input bit q, input bit f);
        @(posedge clk); #1;
        sof = s; go = g; pac = p; gh = q; fr = f;
        model_cycle(s, g, p, q, f);
    endtask

    // One frame: the first cycle is the frame start; hits, eats and idle cycles shuffled.
    task automatic drive_frame(input int nh, input int ne, input int ni, input bit go_sof, input bit go_mid);
        int h, e, idl, total, r;
        bit mid_done;
        h = nh; e = ne; idl = (ni < 2) ? 2 : ni; mid_done = 0;
        total = h + e + idl;
        for (int c = 0; c < total; c++) begin
            r = $urandom_range(h + e + idl - 1);
            if (r < h) begin
                h--; drive(c == 0, c == 0 && go_sof, 1, 1, 0);
            end else if (r < h + e) begin
                e--; drive(c == 0, c == 0 && go_sof, 1, 1, 1);
            end else begin
                bit p, q, gmid;
                idl--;
                p = $urandom_range(1);
                q = p ? 1'b0 : 1'($urandom_range(1));
                gmid = go_mid && !mid_done && c > 0;
                if (gmid) mid_done = 1;
                drive(c == 0, (c == 0 && go_sof) || gmid, p, q, 1'($urandom_range(1)));
            end
        end
    endtask

    task automatic rand_frame(input int hmin, input int hmax);
        drive_frame($urandom_range(hmax, hmin), $urandom_range(5), $urandom_range(3), 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1; sof = 0; go = 0; pac = 0; gh = 0; fr = 0;
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        n_tests++;
        if ({strike, eaten, invuln, dead, vis} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_state: got s/e/i/d/v=%b required 00001", {strike, eaten, invuln, dead, vis});
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_queue: %0d unchecked entries, required 0", exp_q.size());
        end
    endtask

    // Monitor: pops one expectation the cycle after every event, otherwise requires silence on pulses.
    bit prev_rst = 1'b1;
    bit prev_evt = 1'b0;
    always @(negedge clk) begin
        logic [4:0] e;
        if (!prev_rst) begin
            if (prev_evt) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_eval: no expected entry for DUT output s/e/i/d/v=%b", {strike, eaten, invuln, dead, vis});
                end else begin
                    e = exp_q.pop_front();
                    if ({strike, eaten, invuln, dead, vis} !== e) begin
                        n_fail++;
                        $display("FAIL frame_eval @%0t: got s/e/i/d/v=%b required %b", $time, {strike, eaten, invuln, dead, vis}, e);
                    end
                end
            end else begin
                n_tests++;
                if (strike !== 1'b0 || eaten !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stray_pulse @%0t: got strike=%b eaten=%b required 0 0", $time, strike, eaten);
                end
            end
        end
        prev_rst = reset;
        prev_evt = !reset && (sof || go);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Thresholds, saturation, strike, eat in INVULN, window length, lives cap, game over.
        do_reset();
        drive_frame(0, 0, 3, 0, 0);
        drive_frame(3, 0, 3, 0, 0);
        drive_frame(259, 0, 2, 0, 0);
        drive_frame(0, 5, 2, 0, 0);
        drive_frame(0, 3, 2, 0, 0);
        repeat (3 * (INVULN_FRAMES + 4)) rand_frame(4, 6);
        drive_frame(300, 0, 2, 0, 0);
        drive_frame(0, 0, 2, 0, 0);
        drive_frame(2, 2, 4, 0, 1);
        drive_frame(6, 6, 2, 0, 0);
        drive_frame(0, 0, 2, 0, 0);

        // gameOver on the frame start that would have evaluated a hit frame.
        do_reset();
        drive_frame(0, 0, 2, 0, 0);
        drive_frame(4, 5, 2, 0, 0);
        drive_frame(5, 5, 2, 1, 0);
        drive_frame(0, 0, 2, 0, 0);

        // Saturating count issues exactly one strike after reset.
        do_reset();
        drive_frame(0, 0, 2, 0, 0);
        drive_frame(300, 0, 2, 0, 0);
        drive_frame(0, 0, 2, 0, 0);

        // Random traffic with occasional game over.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            drive_frame($urandom_range(6), $urandom_range(6), $urandom_range(4),
                        $urandom_range(99) < 2, $urandom_range(99) < 2);
        end

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d unchecked entries, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
